// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - issue-side stage/slot sequencer for the 1024-point in-place FFT
module fft_stage_sequencer #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_wb_valid,
  output logic       o_rd_en,
  output logic [7:0] o_rd_addr1,
  output logic [7:0] o_rd_addr2,
  output logic       o_dp_valid,
  output logic [7:0] o_dp_addr1,
  output logic [7:0] o_dp_addr2,
  output logic [9:0] o_dp_stride,
  output logic [8:0] o_dp_twiddle1,
  output logic [8:0] o_dp_twiddle2,
  output logic [8:0] o_dp_twiddle3,
  output logic [8:0] o_dp_twiddle4,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_stage,
  output logic       o_err
);

  // addr1, addr2, stride, four twiddles
  localparam int PW = 8 + 8 + 10 + 36;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state;
  logic [6:0]    k;
  logic [7:0]    wb_cnt;
  logic [9:0]    iss_stride;
  logic [35:0]   iss_tw;

  logic          wb_hit;
  logic [8:0]    cnt_sum;
  logic [7:0]    cnt_sat;
  logic          drain_done;
  logic          issue_next;
  logic [3:0]    nxt_s;
  logic [6:0]    nxt_k;
  logic [7:0]    nxt_a1;
  logic [7:0]    nxt_a2;
  logic [2:0]    nxt_b;
  logic [35:0]   nxt_tw;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [PW-1:0]           pipe_data [READ_LATENCY];

  // Bit position where the butterfly partner bit is spliced into the word address.
  function automatic logic [2:0] split_bit(input logic [3:0] s);
    return (s < 4'd2) ? 3'd0 : 3'(s - 4'd2);
  endfunction

  function automatic logic [7:0] top_addr(input logic [3:0] s, input logic [6:0] kk);
    logic [7:0] k8;
    logic [7:0] low;
    k8  = {1'b0, kk};
    low = (8'd1 << split_bit(s)) - 8'd1;
    return ((k8 & ~low) << 1) | (k8 & low);
  endfunction

  function automatic logic [8:0] tw_gen(input logic [3:0] s, input logic [6:0] kk,
                                        input logic [1:0] n);
    logic [8:0] m;
    logic [8:0] mask;
    logic [8:0] masked;
    m      = {kk, n};
    mask   = 9'((10'd1 << s) - 10'd1);
    masked = m & mask;
    return masked << (4'd9 - s);
  endfunction

  // Writeback accounting and selection of the slot to present on the next cycle.
  always_comb begin
    wb_hit     = i_wb_valid && (state != IDLE);
    cnt_sum    = {1'b0, wb_cnt} + {8'd0, wb_hit};
    cnt_sat    = (cnt_sum >= 9'd128) ? 8'd128 : cnt_sum[7:0];
    drain_done = (state == DRAIN) && (cnt_sum >= 9'd128);
    issue_next = 1'b0;
    nxt_s      = o_stage;
    nxt_k      = k + 7'd1;
    case (state)
      IDLE: begin
        if (i_start) begin
          issue_next = 1'b1;
          nxt_s      = 4'd0;
          nxt_k      = 7'd0;
        end
      end
      ISSUE: begin
        if (k != 7'd127) issue_next = 1'b1;
      end
      DRAIN: begin
        if (drain_done && (o_stage != 4'd9)) begin
          issue_next = 1'b1;
          nxt_s      = o_stage + 4'd1;
          nxt_k      = 7'd0;
        end
      end
      default: issue_next = 1'b0;
    endcase
    nxt_b  = split_bit(nxt_s);
    nxt_a1 = top_addr(nxt_s, nxt_k);
    nxt_a2 = nxt_a1 | (8'd1 << nxt_b);
    nxt_tw = {tw_gen(nxt_s, nxt_k, 2'd0), tw_gen(nxt_s, nxt_k, 2'd1),
              tw_gen(nxt_s, nxt_k, 2'd2), tw_gen(nxt_s, nxt_k, 2'd3)};
  end

  // Stage/slot FSM with registered read strobe, read addresses and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      o_stage    <= 4'd0;
      k          <= 7'd0;
      wb_cnt     <= 8'd0;
      o_rd_en    <= 1'b0;
      o_rd_addr1 <= 8'd0;
      o_rd_addr2 <= 8'd0;
      iss_stride <= 10'd0;
      iss_tw     <= 36'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_rd_en <= issue_next;
      if (issue_next) begin
        o_stage    <= nxt_s;
        k          <= nxt_k;
        o_rd_addr1 <= nxt_a1;
        o_rd_addr2 <= nxt_a2;
        iss_stride <= 10'd1 << nxt_s;
        iss_tw     <= nxt_tw;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= ISSUE;
            wb_cnt <= 8'd0;
            o_busy <= 1'b1;
            o_err  <= 1'b0;
          end
        end
        ISSUE: begin
          wb_cnt <= cnt_sat;
          // Reaching the full count before every read is out means the datapath overran.
          if (wb_hit && (cnt_sum >= 9'd128)) o_err <= 1'b1;
          if (k == 7'd127) state <= DRAIN;
        end
        DRAIN: begin
          if (wb_hit && (wb_cnt == 8'd128)) o_err <= 1'b1;
          if (drain_done) begin
            wb_cnt <= 8'd0;
            if (o_stage == 4'd9) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end else begin
            wb_cnt <= cnt_sat;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line that aligns the datapath fields with the SRAM read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= o_rd_en;
      pipe_data[0]  <= {o_rd_addr1, o_rd_addr2, iss_stride, iss_tw};
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign o_dp_valid    = pipe_valid[READ_LATENCY-1];
  assign o_dp_addr1    = pipe_data[READ_LATENCY-1][61:54];
  assign o_dp_addr2    = pipe_data[READ_LATENCY-1][53:46];
  assign o_dp_stride   = pipe_data[READ_LATENCY-1][45:36];
  assign o_dp_twiddle1 = pipe_data[READ_LATENCY-1][35:27];
  assign o_dp_twiddle2 = pipe_data[READ_LATENCY-1][26:18];
  assign o_dp_twiddle3 = pipe_data[READ_LATENCY-1][17:9];
  assign o_dp_twiddle4 = pipe_data[READ_LATENCY-1][8:0];

endmodule
